// File: rtl/rs_pkg.sv
// Shared constants for the byte-serial RS(32,28) encoder over GF(256).
// The generator polynomial and frame length are fixed here.
package rs_pkg;

  localparam int RS_N    = 32;
  localparam int RS_K    = 28;
  localparam int RS_NPAR = 4;

  localparam logic [8:0] GF_PRIM = 9'h11D;

  // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^0..alpha^3
  localparam logic [7:0] RS_G3 = 8'h0F;
  localparam logic [7:0] RS_G2 = 8'h36;
  localparam logic [7:0] RS_G1 = 8'h78;
  localparam logic [7:0] RS_G0 = 8'h40;

  localparam logic [4:0] RS_CNT_KM1 = 5'd27;
  localparam logic [4:0] RS_CNT_NM1 = 5'd31;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } rs_state_e;

endpackage

// File: rtl/gf256_mult.sv
// Combinational GF(256) multiplier, field polynomial GF_PRIM.
// Shift-and-add with per-step reduction, fully unrolled.
module gf256_mult
  import rs_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] acc_s;
  logic [7:0] sh_s;

  // Accumulate a*x^i for each set bit of b, reducing a*x^i every step.
  always_comb begin
    acc_s = 8'h00;
    sh_s  = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) begin
        acc_s = acc_s ^ sh_s;
      end else begin
        acc_s = acc_s;
      end
      sh_s = {sh_s[6:0], 1'b0} ^ (sh_s[7] ? GF_PRIM[7:0] : 8'h00);
    end
  end

  assign p_o = acc_s;

endmodule

// File: rtl/rs_enc_lfsr.sv
// Systematic RS(32,28) encoder: passes 28 message bytes through, then
// emits the 4 LFSR remainder bytes (p3 first) on a valid/ready stream.
module rs_enc_lfsr
  import rs_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_resb,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_sof,
  output logic       o_eof,
  input  logic       i_ready,
  output logic       o_busy
);

  rs_state_e  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       sof_q, sof_d;
  logic       eof_q, eof_d;
  logic       busy_q, busy_d;

  logic       free_s, ready_s, in_xfer_s;
  logic [7:0] fb_s, prod0_s, prod1_s, prod2_s, prod3_s;

  assign free_s    = ~valid_q | i_ready;
  assign ready_s   = (state_q == S_DATA) & free_s;
  assign in_xfer_s = i_valid & ready_s;
  assign fb_s      = i_data ^ p3_q;

  gf256_mult u_mul3 (.a_i(fb_s), .b_i(RS_G3), .p_o(prod3_s));
  gf256_mult u_mul2 (.a_i(fb_s), .b_i(RS_G2), .p_o(prod2_s));
  gf256_mult u_mul1 (.a_i(fb_s), .b_i(RS_G1), .p_o(prod1_s));
  gf256_mult u_mul0 (.a_i(fb_s), .b_i(RS_G0), .p_o(prod0_s));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    case (state_q)
      S_DATA: begin
        if (in_xfer_s) begin
          p3_d    = p2_q ^ prod3_s;
          p2_d    = p1_q ^ prod2_s;
          p1_d    = p0_q ^ prod1_s;
          p0_d    = prod0_s;
          data_d  = i_data;
          valid_d = 1'b1;
          sof_d   = (cnt_q == 5'd0);
          eof_d   = 1'b0;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == RS_CNT_KM1) begin
            state_d = S_PAR;
          end else begin
            state_d = S_DATA;
          end
        end else if (free_s) begin
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eof_d   = 1'b0;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PAR: begin
        // Parity drains out as a plain shift; zeros fill in behind it.
        if (free_s) begin
          data_d  = p3_q;
          valid_d = 1'b1;
          sof_d   = 1'b0;
          eof_d   = (cnt_q == RS_CNT_NM1);
          p3_d    = p2_q;
          p2_d    = p1_q;
          p1_d    = p0_q;
          p0_d    = 8'h00;
          if (cnt_q == RS_CNT_NM1) begin
            cnt_d   = 5'd0;
            state_d = S_DATA;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = S_PAR;
          end
        end else begin
          state_d = S_PAR;
        end
      end
      default: begin
        state_d = S_DATA;
        cnt_d   = 5'd0;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
      end
    endcase
    busy_d = (cnt_d != 5'd0) | valid_d;
  end

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      state_q <= S_DATA;
      cnt_q   <= 5'd0;
      p0_q    <= 8'h00;
      p1_q    <= 8'h00;
      p2_q    <= 8'h00;
      p3_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ready = ready_s;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_sof   = sof_q;
  assign o_eof   = eof_q;
  assign o_busy  = busy_q;

endmodule
